multi_alarm_clock: RTL and testbench
====================================

MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
- REQ-001 Parameter NUM_ALARMS, default 4, number of independent alarm slots (1..8).
- REQ-002 Parameter CYCLES_PER_MIN, default 15360, clk cycles per clock minute.
- REQ-003 Parameter SNOOZE_MIN, default 5, snooze delay in minutes (1..59).
- REQ-004 clk  in  1  single clock, rising edge; all state is clocked on it.
- REQ-005 reset  in  1  asynchronous, active-high reset.
- REQ-006 alarm_button  in  1  starts keypad entry of the alarm selected by alarm_sel.
- REQ-007 time_button  in  1  starts keypad entry of the current time.
- REQ-008 keypad_buttons  in  10  one-hot digit keys; bit n is digit n.
- REQ-009 alarm_sel  in  clog2(NUM_ALARMS), minimum 1  alarm slot index.
- REQ-010 alarm_off  in  1  clears all ringing alarms.
- REQ-011 snooze_button  in  1  snooze request (REQ-030).
- REQ-012 hours  out  5  current hour, 0..23.
- REQ-013 minutes  out  6  current minute, 0..59.
- REQ-014 alarm_ring  out  NUM_ALARMS  per-slot ringing flag.
- REQ-015 alarm_any  out  1  OR of alarm_ring.
- REQ-016 entry_active  out  1  high while keypad entry is in progress.

Function
- REQ-017 Prescaler counts 0..CYCLES_PER_MIN-1 and wraps; the wrap cycle is the minute tick.
- REQ-018 On a minute tick, minutes increments; 59 wraps to 0 and increments hours; 23:59 wraps to 00:00.
- REQ-019 All inputs are edge-detected on registered copies; only rising edges act.
- REQ-020 A keypad edge with more than one bit set, or with zero bits set, is ignored.
- REQ-021 Entry FSM states: IDLE, D0, D1, D2, D3, COMMIT.
- REQ-022 IDLE plus time_button edge goes to D0 with target = time.
- REQ-023 IDLE plus alarm_button edge goes to D0 with target = alarm[alarm_sel], sampled on that cycle.
- REQ-024 If both buttons rise in the same cycle, time wins.
- REQ-025 Each valid key advances D0 to D1 to D2 to D3 to COMMIT; digits are H1, H0, M1, M0.
- REQ-026 Either button edge while in D0..D3 aborts entry and returns to IDLE with no write.
- REQ-027 COMMIT lasts 1 cycle, then IDLE.
  - If HH>23 or MM>59, the entry is discarded silently.
  - Otherwise the target is written on the COMMIT cycle, visible the next cycle.
  - A time write clears the prescaler; a minute tick in the same cycle is lost.
  - An alarm write stores HH:MM and sets that slot's enable.
- REQ-028 A slot rings (alarm_ring[i] set, sticky) when the slot is enabled and its time equals the current time, on the cycle after a minute tick or a time write.
- REQ-029 An alarm_off edge clears all alarm_ring bits; enables are kept. If alarm_off coincides with a match, clear wins.
- REQ-030 snooze_button behaviour depends on SNOOZE_EN (REQ-034).

Reset
- REQ-031 Reset returns to these values: time 00:00, prescaler 0, FSM IDLE, all alarm times 00:00, all enables 0, alarm_ring 0, alarm_any 0, entry_active 0, all edge registers 0.
- REQ-032 Reset asserted mid-entry discards the partial entry.
- REQ-033 All outputs are registered.

Configuration
- REQ-034 Macro ALARM_CLOCK_SNOOZE_EN.
  - When defined: a snooze_button edge clears the ringing slots and re-arms each of them SNOOZE_MIN minutes later (mod 24h) via a per-slot snooze time. The original alarm time is unchanged.
  - When not defined: snooze_button is ignored and no snooze storage is built.

Structure
- REQ-035 Package alarm_clock_pkg holds: the entry FSM state enum, a time struct {hours[4:0], minutes[5:0]}, and constants MAX_HOUR=23 and MAX_MIN=59.
- REQ-036 Sub-module keypad_entry holds the edge detect, FSM, digit shift register and range check. It outputs a commit strobe, the target and HH:MM.

Verification
- REQ-037 Release reset, run 434*15360 cycles -> hours=7, minutes=14.
- REQ-038 time_button, keys 0,4,3,5 -> hours=4, minutes=35 the cycle after COMMIT; prescaler=0.
- REQ-039 At 04:35, alarm_sel=1, alarm_button, keys 0,4,3,6 -> alarm_ring=4'b0010 one cycle after the next minute tick; alarm_any=1; alarm_off edge -> 0.
- REQ-040 time_button, keys 2,5,0,0 -> entry discarded, time unchanged. Keys 1 and 2 pressed together -> ignored, FSM stays in D0.
- REQ-041 Press alarm_button mid-entry after 2 digits -> IDLE, entry_active=0, no write. Press both buttons in IDLE -> target = time.
- REQ-042 With ALARM_CLOCK_SNOOZE_EN: ringing at 04:36, snooze edge -> ring clears and reasserts at 04:41.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the multi-alarm clock.
// Optional snooze storage is built when ALARM_CLOCK_SNOOZE_EN is defined.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_D0     = 3'd1,
    ST_D1     = 3'd2,
    ST_D2     = 3'd3,
    ST_D3     = 3'd4,
    ST_COMMIT = 3'd5
  } entry_state_e;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
  } hm_t;

  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;

  // Add up to 59 minutes, wrapping at 24h.
  function automatic hm_t hm_add(hm_t t, logic [5:0] add);
    hm_t        r;
    logic [6:0] m;
    r = t;
    m = 7'(t.minutes) + 7'(add);
    if (m > 7'(MAX_MIN)) begin
      m = m - 7'd60;
      r.hours = (t.hours == 5'(MAX_HOUR)) ? 5'd0 : t.hours + 5'd1;
    end
    r.minutes = m[5:0];
    return r;
  endfunction

endpackage

// File: rtl/keypad_entry.sv
// Button/key edge detect, four-digit HH:MM entry FSM and range check.
// commit_o pulses in COMMIT only when the entered time is in range.
module keypad_entry
  import alarm_clock_pkg::*;
#(
  parameter int SEL_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             time_btn_i,
  input  logic             alarm_btn_i,
  input  logic [9:0]       keys_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic             commit_o,
  output logic             tgt_time_o,
  output logic [SEL_W-1:0] sel_o,
  output hm_t              hm_o,
  output logic             active_o
);

  entry_state_e     state_q, state_d;
  logic             tbtn_q, abtn_q;
  logic [9:0]       keys_q;
  logic             tgt_q, tgt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic             active_q;

  logic       t_rise, a_rise, key_ok, in_range;
  logic [9:0] k_rise;
  logic [3:0] key_val;
  logic [6:0] hh, mm;

  assign t_rise = time_btn_i & ~tbtn_q;
  assign a_rise = alarm_btn_i & ~abtn_q;
  assign k_rise = keys_i & ~keys_q;
  assign key_ok = $onehot(k_rise);

  always_comb begin
    key_val = '0;
    for (int i = 0; i < 10; i++)
      if (k_rise[i]) key_val = 4'(i);
  end

  // dig_q[3] holds the first digit typed (H1)
  assign hh = 7'(dig_q[3]) * 7'd10 + 7'(dig_q[2]);
  assign mm = 7'(dig_q[1]) * 7'd10 + 7'(dig_q[0]);
  assign in_range = (hh <= 7'(MAX_HOUR)) && (mm <= 7'(MAX_MIN));

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    sel_d   = sel_q;
    dig_d   = dig_q;
    unique case (state_q)
      ST_IDLE: begin
        if (t_rise) begin
          state_d = ST_D0;
          tgt_d   = 1'b1;
        end else if (a_rise) begin
          state_d = ST_D0;
          tgt_d   = 1'b0;
          sel_d   = sel_i;
        end
      end
      ST_D0, ST_D1, ST_D2, ST_D3: begin
        if (t_rise || a_rise) begin
          state_d = ST_IDLE;
        end else if (key_ok) begin
          dig_d   = {dig_q[2:0], key_val};
          state_d = entry_state_e'(state_q + 3'd1);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tbtn_q   <= 1'b0;
      abtn_q   <= 1'b0;
      keys_q   <= '0;
      tgt_q    <= 1'b0;
      sel_q    <= '0;
      dig_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tbtn_q   <= time_btn_i;
      abtn_q   <= alarm_btn_i;
      keys_q   <= keys_i;
      tgt_q    <= tgt_d;
      sel_q    <= sel_d;
      dig_q    <= dig_d;
      active_q <= (state_d != ST_IDLE);
    end
  end

  assign commit_o   = (state_q == ST_COMMIT) && in_range;
  assign tgt_time_o = tgt_q;
  assign sel_o      = sel_q;
  assign hm_o       = '{hours: hh[4:0], minutes: mm[5:0]};
  assign active_o   = active_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// 24h clock with NUM_ALARMS keypad-programmed alarm slots.
// Snooze re-arm storage is built only with ALARM_CLOCK_SNOOZE_EN.
module multi_alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter  int NUM_ALARMS     = 4,
  parameter  int CYCLES_PER_MIN = 15360,
  parameter  int SNOOZE_MIN     = 5,
  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int PW    = (CYCLES_PER_MIN > 1) ? $clog2(CYCLES_PER_MIN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alarm_button,
  input  logic                  time_button,
  input  logic [9:0]            keypad_buttons,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic                  alarm_off,
  input  logic                  snooze_button,
  output logic [4:0]            hours,
  output logic [5:0]            minutes,
  output logic [NUM_ALARMS-1:0] alarm_ring,
  output logic                  alarm_any,
  output logic                  entry_active
);

  logic             commit, tgt_time;
  logic [SEL_W-1:0] ent_sel;
  hm_t              ent_hm;

  keypad_entry #(.SEL_W(SEL_W)) u_entry (
    .clk        (clk),
    .reset      (reset),
    .time_btn_i (time_button),
    .alarm_btn_i(alarm_button),
    .keys_i     (keypad_buttons),
    .sel_i      (alarm_sel),
    .commit_o   (commit),
    .tgt_time_o (tgt_time),
    .sel_o      (ent_sel),
    .hm_o       (ent_hm),
    .active_o   (entry_active)
  );

  logic [PW-1:0]                presc_q, presc_d;
  hm_t                          now_q, now_d;
  hm_t [NUM_ALARMS-1:0]         alm_q, alm_d;
  logic [NUM_ALARMS-1:0]        en_q, en_d;
  logic [NUM_ALARMS-1:0]        ring_q, ring_d;
  logic                         any_q;
  logic                         off_q;
  logic tick, time_wr, alm_wr, chk, off_rise;

  assign tick     = (presc_q == PW'(CYCLES_PER_MIN - 1));
  assign time_wr  = commit & tgt_time;
  assign alm_wr   = commit & ~tgt_time;
  assign chk      = tick | time_wr;
  assign off_rise = alarm_off & ~off_q;

`ifdef ALARM_CLOCK_SNOOZE_EN
  hm_t [NUM_ALARMS-1:0]  snz_q, snz_d;
  logic [NUM_ALARMS-1:0] snz_en_q, snz_en_d;
  logic                  snzb_q;
  logic                  snz_rise;
  hm_t                   snz_at;

  assign snz_rise = snooze_button & ~snzb_q;
  assign snz_at   = hm_add(now_q, 6'(SNOOZE_MIN));
`else
  logic unused_snooze;
  assign unused_snooze = snooze_button;
`endif

  // A time write restarts the minute and swallows a coincident tick
  always_comb begin
    now_d   = now_q;
    presc_d = presc_q + PW'(1);
    if (time_wr) begin
      now_d   = ent_hm;
      presc_d = '0;
    end else if (tick) begin
      now_d   = hm_add(now_q, 6'd1);
      presc_d = '0;
    end
  end

  always_comb begin
    ring_d = ring_q;
    alm_d  = alm_q;
    en_d   = en_q;
`ifdef ALARM_CLOCK_SNOOZE_EN
    snz_d    = snz_q;
    snz_en_d = snz_en_q;
`endif
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (chk && en_q[i] && alm_q[i] == now_d) ring_d[i] = 1'b1;
`ifdef ALARM_CLOCK_SNOOZE_EN
      if (chk && snz_en_q[i] && snz_q[i] == now_d) begin
        ring_d[i]   = 1'b1;
        snz_en_d[i] = 1'b0;
      end
`endif
    end
    if (off_rise) ring_d = '0;
`ifdef ALARM_CLOCK_SNOOZE_EN
    if (snz_rise) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (ring_q[i]) begin
          snz_d[i]    = snz_at;
          snz_en_d[i] = 1'b1;
        end
      end
      ring_d = '0;
    end
`endif
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (alm_wr && ent_sel == SEL_W'(i)) begin
        alm_d[i] = ent_hm;
        en_d[i]  = 1'b1;
`ifdef ALARM_CLOCK_SNOOZE_EN
        snz_en_d[i] = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      now_q   <= '0;
      alm_q   <= '0;
      en_q    <= '0;
      ring_q  <= '0;
      any_q   <= 1'b0;
      off_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      now_q   <= now_d;
      alm_q   <= alm_d;
      en_q    <= en_d;
      ring_q  <= ring_d;
      any_q   <= |ring_d;
      off_q   <= alarm_off;
    end
  end

`ifdef ALARM_CLOCK_SNOOZE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snz_q    <= '0;
      snz_en_q <= '0;
      snzb_q   <= 1'b0;
    end else begin
      snz_q    <= snz_d;
      snz_en_q <= snz_en_d;
      snzb_q   <= snooze_button;
    end
  end
`endif

  assign hours      = now_q.hours;
  assign minutes    = now_q.minutes;
  assign alarm_ring = ring_q;
  assign alarm_any  = any_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock: directed scenarios plus
// randomized traffic against a minute-count reference model.
module tb_multi_alarm_clock;

  localparam int NA  = 4;
  localparam int CPM = 16;
  localparam int SN  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic [9:0] keypad_buttons = '0;
  logic [1:0] alarm_sel = '0;
  logic       alarm_off = 1'b0;
  logic       snooze_button = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [NA-1:0] alarm_ring;
  logic       alarm_any;
  logic       entry_active;

  multi_alarm_clock #(
    .NUM_ALARMS(NA), .CYCLES_PER_MIN(CPM), .SNOOZE_MIN(SN)
  ) dut (
    .clk(clk), .reset(reset),
    .alarm_button(alarm_button), .time_button(time_button),
    .keypad_buttons(keypad_buttons), .alarm_sel(alarm_sel),
    .alarm_off(alarm_off), .snooze_button(snooze_button),
    .hours(hours), .minutes(minutes), .alarm_ring(alarm_ring),
    .alarm_any(alarm_any), .entry_active(entry_active)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time as minutes since midnight, entry as digit count
  int m_min, m_presc, m_ent, m_sel;
  bit m_tgt;
  int m_al[NA];
  int m_snz[NA];
  int m_dig[4];
  bit [NA-1:0] m_en, m_ring, m_snzen;
  logic p_tb, p_ab, p_off, p_snz;
  logic [9:0] p_kp;

  task automatic model_reset();
    m_min = 0; m_presc = 0; m_ent = 0; m_sel = 0; m_tgt = 0;
    for (int i = 0; i < NA; i++) begin m_al[i] = 0; m_snz[i] = 0; end
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_en = '0; m_ring = '0; m_snzen = '0;
    p_tb = 0; p_ab = 0; p_off = 0; p_snz = 0; p_kp = '0;
  endtask

  task automatic model_step();
    bit tick, te, ae, oe, se, ok, tw, aw, kv;
    logic [9:0] kr;
    bit [NA-1:0] oldr;
    int hh, mm, nmin, kd;
    tick = (m_presc == CPM - 1);
    te = time_button & ~p_tb;
    ae = alarm_button & ~p_ab;
    oe = alarm_off & ~p_off;
    se = snooze_button & ~p_snz;
    kr = keypad_buttons & ~p_kp;
    kv = ($countones(kr) == 1);
    kd = 0;
    for (int i = 0; i < 10; i++) if (kr[i]) kd = i;
    hh = m_dig[0] * 10 + m_dig[1];
    mm = m_dig[2] * 10 + m_dig[3];
    ok = (m_ent == 5) && hh <= 23 && mm <= 59;
    tw = ok && m_tgt;
    aw = ok && !m_tgt;
    if (tw) begin nmin = hh * 60 + mm; m_presc = 0; end
    else if (tick) begin nmin = (m_min + 1) % 1440; m_presc = 0; end
    else begin nmin = m_min; m_presc++; end
    oldr = m_ring;
    for (int i = 0; i < NA; i++) begin
      if ((tick || tw) && m_en[i] && m_al[i] == nmin) m_ring[i] = 1;
`ifdef ALARM_CLOCK_SNOOZE_EN
      if ((tick || tw) && m_snzen[i] && m_snz[i] == nmin) begin
        m_ring[i] = 1; m_snzen[i] = 0;
      end
`endif
    end
    if (oe) m_ring = '0;
`ifdef ALARM_CLOCK_SNOOZE_EN
    if (se) begin
      for (int i = 0; i < NA; i++)
        if (oldr[i]) begin m_snz[i] = (m_min + SN) % 1440; m_snzen[i] = 1; end
      m_ring = '0;
    end
`else
    if (se) oldr = '0;
`endif
    if (aw) begin
      m_al[m_sel] = hh * 60 + mm; m_en[m_sel] = 1; m_snzen[m_sel] = 0;
    end
    m_min = nmin;
    if (m_ent == 0) begin
      if (te) begin m_ent = 1; m_tgt = 1; end
      else if (ae) begin m_ent = 1; m_tgt = 0; m_sel = int'(alarm_sel); end
    end else if (m_ent <= 4) begin
      if (te || ae) m_ent = 0;
      else if (kv) begin m_dig[m_ent - 1] = kd; m_ent++; end
    end else begin
      m_ent = 0;
    end
    p_tb = time_button; p_ab = alarm_button; p_off = alarm_off;
    p_snz = snooze_button; p_kp = keypad_buttons;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic key(input int d);
    keypad_buttons = '0;
    keypad_buttons[d] = 1'b1;
    step();
    keypad_buttons = '0;
    step();
  endtask

  task automatic enter_time(input int a, input int b, input int c, input int d);
    time_button = 1; step(); time_button = 0; step();
    key(a); key(b); key(c); key(d);
  endtask

  task automatic wait_min(input int target, input int bound, input string nm);
    int k;
    k = 0;
    while (m_min != target && k < bound) begin step(); k++; end
    if (m_min != target) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: model at %0d, wanted %0d", nm, m_min, target);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_tests++;
    if (hours !== 5'd0 || minutes !== 6'd0) begin
      n_fail++; $display("FAIL reset_time: got %0d:%0d want 0:0", hours, minutes);
    end
    n_tests++;
    if (alarm_ring !== '0 || alarm_any !== 1'b0 || entry_active !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: ring=%b any=%b act=%b want 0", alarm_ring, alarm_any, entry_active);
    end
    reset = 0;
    time_button = 1; step(); time_button = 0; step();
    key(1);
    n_tests++;
    if (entry_active !== 1'b1) begin
      n_fail++; $display("FAIL entry_started: act=%b want 1", entry_active);
    end
    reset = 1;
    #2;
    model_reset();
    n_tests++;
    if (entry_active !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_entry: act=%b want 0", entry_active);
    end
    reset = 0;
  endtask

  task automatic test_count();
    reset = 1; #1; reset = 0;
    model_reset();
    repeat (434 * CPM - 1) step();
    n_tests++;
    if (hours !== 5'd7 || minutes !== 6'd13) begin
      n_fail++; $display("FAIL count_pre: got %0d:%0d want 7:13", hours, minutes);
    end
    step();
    n_tests++;
    if (hours !== 5'd7 || minutes !== 6'd14) begin
      n_fail++; $display("FAIL count_434: got %0d:%0d want 7:14", hours, minutes);
    end
  endtask

  task automatic test_time_set();
    enter_time(0, 4, 3, 5);
    n_tests++;
    if (hours !== 5'd4 || minutes !== 6'd35 || entry_active !== 1'b0) begin
      n_fail++;
      $display("FAIL time_set: got %0d:%0d act=%b want 4:35 act=0", hours, minutes, entry_active);
    end
    repeat (CPM - 1) step();
    n_tests++;
    if (minutes !== 6'd35) begin
      n_fail++; $display("FAIL presc_clear_hold: got min %0d want 35", minutes);
    end
    step();
    n_tests++;
    if (minutes !== 6'd36) begin
      n_fail++; $display("FAIL presc_clear_tick: got min %0d want 36", minutes);
    end
  endtask

  task automatic test_alarm();
    enter_time(0, 4, 3, 5);
    alarm_sel = 2'd1;
    alarm_button = 1; step(); alarm_button = 0; step();
    alarm_sel = 2'd3;
    key(0); key(4); key(3); key(6);
    n_tests++;
    if (alarm_ring !== 4'b0000) begin
      n_fail++; $display("FAIL alarm_early: ring=%b want 0000", alarm_ring);
    end
    wait_min(4 * 60 + 36, 2 * CPM, "alarm_wait");
    n_tests++;
    if (alarm_ring !== 4'b0010 || alarm_any !== 1'b1 || minutes !== 6'd36) begin
      n_fail++;
      $display("FAIL alarm_ring: ring=%b any=%b min=%0d want 0010 1 36", alarm_ring, alarm_any, minutes);
    end
    alarm_off = 1; step();
    n_tests++;
    if (alarm_ring !== 4'b0000 || alarm_any !== 1'b0) begin
      n_fail++; $display("FAIL alarm_off: ring=%b any=%b want 0000 0", alarm_ring, alarm_any);
    end
    alarm_off = 0; step();
  endtask

  task automatic test_bad_entry();
    enter_time(2, 5, 0, 0);
    n_tests++;
    if (hours !== 5'(m_min / 60) || minutes !== 6'(m_min % 60) || hours === 5'd25) begin
      n_fail++;
      $display("FAIL bad_entry: got %0d:%0d want %0d:%0d", hours, minutes, m_min / 60, m_min % 60);
    end
    time_button = 1; step(); time_button = 0; step();
    keypad_buttons = 10'b0000000110; step();
    keypad_buttons = '0; step();
    n_tests++;
    if (entry_active !== 1'b1) begin
      n_fail++; $display("FAIL multi_key: act=%b want 1", entry_active);
    end
    key(0); key(5); key(0); key(0);
    n_tests++;
    if (hours !== 5'd5 || minutes !== 6'd0) begin
      n_fail++; $display("FAIL multi_key_ignored: got %0d:%0d want 5:0", hours, minutes);
    end
  endtask

  task automatic test_abort();
    alarm_sel = 2'd2;
    alarm_button = 1; step(); alarm_button = 0; step();
    key(1); key(1);
    alarm_button = 1; step(); alarm_button = 0; step();
    n_tests++;
    if (entry_active !== 1'b0) begin
      n_fail++; $display("FAIL abort: act=%b want 0", entry_active);
    end
    key(0); key(0);
    enter_time(1, 1, 0, 0);
    n_tests++;
    if (hours !== 5'd11 || minutes !== 6'd0 || alarm_ring !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_nowrite: got %0d:%0d ring=%b want 11:0 0000", hours, minutes, alarm_ring);
    end
    time_button = 1; alarm_button = 1; step();
    time_button = 0; alarm_button = 0; step();
    key(1); key(2); key(3); key(4);
    n_tests++;
    if (hours !== 5'd12 || minutes !== 6'd34) begin
      n_fail++; $display("FAIL both_buttons: got %0d:%0d want 12:34", hours, minutes);
    end
  endtask

  task automatic test_snooze();
    enter_time(0, 4, 3, 5);
    wait_min(4 * 60 + 36, 2 * CPM, "snooze_first");
    n_tests++;
    if (alarm_ring !== 4'b0010) begin
      n_fail++; $display("FAIL snooze_first_ring: ring=%b want 0010", alarm_ring);
    end
    snooze_button = 1; step();
`ifdef ALARM_CLOCK_SNOOZE_EN
    n_tests++;
    if (alarm_ring !== 4'b0000) begin
      n_fail++; $display("FAIL snooze_clear: ring=%b want 0000", alarm_ring);
    end
    snooze_button = 0; step();
    wait_min(4 * 60 + 40, 6 * CPM, "snooze_quiet");
    n_tests++;
    if (alarm_ring !== 4'b0000) begin
      n_fail++; $display("FAIL snooze_quiet: ring=%b want 0000", alarm_ring);
    end
    wait_min(4 * 60 + 41, 2 * CPM, "snooze_rearm");
    n_tests++;
    if (alarm_ring !== 4'b0010 || minutes !== 6'd41) begin
      n_fail++; $display("FAIL snooze_rearm: ring=%b min=%0d want 0010 41", alarm_ring, minutes);
    end
`else
    n_tests++;
    if (alarm_ring !== 4'b0010) begin
      n_fail++; $display("FAIL snooze_ignored: ring=%b want 0010", alarm_ring);
    end
    snooze_button = 0; step();
`endif
    alarm_off = 1; step(); alarm_off = 0; step();
  endtask

  task automatic test_random();
    int r, d;
    for (int c = 0; c < 4000; c++) begin
      time_button   = ($urandom_range(0, 99) < 3);
      alarm_button  = ($urandom_range(0, 99) < 4);
      alarm_sel     = 2'($urandom_range(0, 3));
      alarm_off     = ($urandom_range(0, 99) < 2);
      snooze_button = ($urandom_range(0, 99) < 3);
      r = $urandom_range(0, 99);
      keypad_buttons = '0;
      if (r < 40) begin
        if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 9);
        else if (m_ent == 1) begin
          r = $urandom_range(0, 2);
          d = (r == 0) ? 0 : (r == 1) ? 2 : 9;
        end else if (m_ent == 2) d = $urandom_range(0, 1) ? 4 : 3;
        else if (m_ent == 3) d = $urandom_range(0, 1) ? 3 : 6;
        else d = $urandom_range(5, 7);
        keypad_buttons[d] = 1'b1;
      end else if (r < 43) begin
        keypad_buttons[$urandom_range(0, 4)] = 1'b1;
        keypad_buttons[$urandom_range(5, 9)] = 1'b1;
      end
      step();
      n_tests++;
      if (hours !== 5'(m_min / 60) || minutes !== 6'(m_min % 60) ||
          alarm_ring !== m_ring || alarm_any !== (|m_ring) ||
          entry_active !== (m_ent != 0)) begin
        n_fail++;
        $display("FAIL random c%0d: got %0d:%0d ring=%b any=%b act=%b want %0d:%0d ring=%b any=%b act=%b",
                 c, hours, minutes, alarm_ring, alarm_any, entry_active,
                 m_min / 60, m_min % 60, m_ring, |m_ring, m_ent != 0);
      end
    end
    time_button = 0; alarm_button = 0; alarm_off = 0;
    snooze_button = 0; keypad_buttons = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_time_set();
    test_alarm();
    test_bad_entry();
    test_abort();
    test_snooze();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
